// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic phase controllers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } phase_t;

  // Lamp triplet order is {Red, Yellow, Green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Lamp pattern for one approach given the controller phase.
  function automatic logic [2:0] lamp_for(input phase_t ph,
                                          input logic   is_active,
                                          input logic   flash_on);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    case (ph)
      GREEN:   lamp = is_active ? LAMP_GRN : LAMP_RED;
      YELLOW:  lamp = is_active ? LAMP_YEL : LAMP_RED;
      FLASH:   lamp = flash_on ? LAMP_YEL : LAMP_OFF;
      default: lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/lamp bundle between the tick source, the controller and the lamp drivers.
interface traffic_phase_ctrl_if #(
  parameter int unsigned NUM_DIR = 2
) ();
  localparam int unsigned DIR_W = $clog2(NUM_DIR);

  logic                   tick_en;
  logic [NUM_DIR-1:0]     ped_req;
  logic                   flash_mode;
  logic [3*NUM_DIR-1:0]   lights;
  logic [NUM_DIR-1:0]     walk;
  logic [DIR_W-1:0]       active_dir;
  logic                   in_flash;

  modport master (
    output tick_en, ped_req, flash_mode,
    input  lights, walk, active_dir, in_flash
  );

  modport slave (
    input  tick_en, ped_req, flash_mode,
    output lights, walk, active_dir, in_flash
  );
endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Tick-driven phase timer: counts 0..limit on tick_en and flags expiry.
module phase_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               load,
  input  logic [TIMER_W-1:0] limit,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  assign expire = tick_en && !load && (count == limit);

  // Count ticks, wrapping to zero on expiry; load holds the count at zero.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (tick_en) begin
      count <= expire ? '0 : count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic phase controller with pedestrian walk and flashing-yellow mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR      = 2,
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  ctrl
);

  localparam int unsigned DIR_W = $clog2(NUM_DIR);

  localparam logic [TIMER_W-1:0] GREEN_LIM  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LIM = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LIM = TIMER_W'(ALLRED_TICKS - 1);
  localparam logic [DIR_W-1:0]   LAST_DIR   = DIR_W'(NUM_DIR - 1);

  phase_t             state;
  logic [DIR_W-1:0]   active_dir;
  logic               flash_phase;
  logic               expire;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_limit;
  logic               go_green;
  logic [NUM_DIR-1:0] ped_pending;
  logic [NUM_DIR-1:0] walk_grant;

  // FLASH is paced by ticks directly, so the timer is parked at zero there.
  assign timer_load = (state == FLASH);
  assign go_green   = (state == ALL_RED) && expire && !ctrl.flash_mode;

  // Duration of the phase currently being timed.
  always_comb begin
    timer_limit = ALLRED_LIM;
    case (state)
      GREEN:   timer_limit = GREEN_LIM;
      YELLOW:  timer_limit = YELLOW_LIM;
      default: timer_limit = ALLRED_LIM;
    endcase
  end

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_en (ctrl.tick_en),
    .load    (timer_load),
    .limit   (timer_limit),
    .expire  (expire)
  );

  // Phase sequencing, approach rotation and flash blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALL_RED;
      active_dir  <= '0;
      flash_phase <= 1'b0;
    end else begin
      case (state)
        ALL_RED: begin
          if (expire) begin
            if (ctrl.flash_mode) begin
              state       <= FLASH;
              flash_phase <= 1'b0;
            end else begin
              state <= GREEN;
            end
          end
        end
        GREEN: begin
          if (expire) state <= YELLOW;
        end
        YELLOW: begin
          if (expire) begin
            state      <= ALL_RED;
            active_dir <= (active_dir == LAST_DIR) ? '0 : active_dir + DIR_W'(1);
          end
        end
        FLASH: begin
          if (ctrl.tick_en) begin
            if (!ctrl.flash_mode) begin
              state       <= ALL_RED;
              active_dir  <= '0;
              flash_phase <= 1'b0;
            end else begin
              flash_phase <= ~flash_phase;
            end
          end
        end
        default: begin
          state <= ALL_RED;
        end
      endcase
    end
  end

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    logic is_active;
    logic pend_q;
    logic grant_q;

    assign is_active = (active_dir == DIR_W'(d));

    // Latch requests until this approach's green starts, then convert them into a walk grant.
    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q  <= 1'b0;
        grant_q <= 1'b0;
      end else if (go_green && is_active) begin
        grant_q <= pend_q | ctrl.ped_req[d];
        pend_q  <= 1'b0;
      end else if (ctrl.ped_req[d]) begin
        pend_q <= 1'b1;
      end
    end

    assign ped_pending[d]          = pend_q;
    assign walk_grant[d]           = grant_q;
    assign ctrl.lights[3*d +: 3]   = lamp_for(state, is_active, flash_phase);
    assign ctrl.walk[d]            = walk_grant[d] && is_active && (state == GREEN);
  end

  assign ctrl.active_dir = active_dir;
  assign ctrl.in_flash   = (state == FLASH);

endmodule
